// File: rtl/alu_scheduler_pkg.sv
// Shared CPU definitions: ALU opcodes, NZCV bit positions, per-op flag masks
// and the scheduler's internal state/op-register types.
package alu_scheduler_pkg;

  typedef enum logic [3:0] {
    OP_PASS  = 4'd0,
    OP_OR    = 4'd1,
    OP_AND   = 4'd2,
    OP_XOR   = 4'd3,
    OP_ADD   = 4'd4,
    OP_ADC   = 4'd5,
    OP_SUB   = 4'd6,
    OP_SUBC  = 4'd7,
    OP_SHL   = 4'd8,
    OP_SHR   = 4'd9,
    OP_ROL   = 4'd10,
    OP_ROR   = 4'd11,
    OP_ADD16 = 4'd12
  } alu_op_e;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  typedef struct packed {
    logic [3:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic        id;
    logic        setflags;
  } op_reg_t;

  function automatic logic op_is_defined(input logic [3:0] op);
    return op <= OP_ADD16;
  endfunction

  // Returns the {N,Z,C,V} bits an op is allowed to write; undefined ops write none.
  function automatic logic [3:0] flag_mask(input logic [3:0] op);
    logic [3:0] m;
    m = 4'b0000;
    case (op)
      OP_PASS, OP_OR, OP_AND, OP_XOR:  m = 4'b1100;
      OP_ADD, OP_ADC, OP_SUB, OP_SUBC: m = 4'b1111;
      OP_SHL, OP_SHR, OP_ROL, OP_ROR:  m = 4'b1110;
      default:                         m = 4'b0000;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/alu_scheduler_rr_arb2.sv
// Two-way arbiter: round-robin on contention, or fixed priority to requester 0.
module rr_arb2 #(
  parameter bit ROUND_ROBIN = 1'b1
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic [1:0] req,
  input  logic       advance,
  output logic       gnt_valid,
  output logic       gnt_id
);

  logic last_reg;

  // Reset to requester 1 so the first contended grant goes to requester 0.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      last_reg <= 1'b1;
    end else if (advance && gnt_valid) begin
      last_reg <= gnt_id;
    end
  end

  always_comb begin
    gnt_valid = |req;
    gnt_id    = 1'b0;
    if (req == 2'b11) begin
      gnt_id = ROUND_ROBIN ? ~last_reg : 1'b0;
    end else if (req == 2'b10) begin
      gnt_id = 1'b1;
    end
  end

endmodule

// File: rtl/alu_scheduler.sv
// Single-issue ALU scheduler: arbitrates two requesters onto one external ALU,
// returns one registered response per operation and owns the NZCV flags.
module alu_scheduler
  import alu_scheduler_pkg::*;
#(
  parameter bit ROUND_ROBIN = 1'b1
) (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [3:0]  req0_op,
  input  logic [15:0] req0_a,
  input  logic [15:0] req0_b,
  input  logic        req0_setflags,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [3:0]  req1_op,
  input  logic [15:0] req1_a,
  input  logic [15:0] req1_b,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_id,
  output logic [15:0] rsp_data,
  output logic        rsp_pagecross,
  input  logic        flag_wr_en,
  input  logic [3:0]  flag_wr_data,
  output logic [3:0]  flags,
  output logic [3:0]  alu_op,
  output logic [7:0]  aluh0,
  output logic [7:0]  aluh1,
  output logic [7:0]  alul0,
  output logic [7:0]  alul1,
  output logic        alu_cin,
  input  logic [7:0]  aluh_out,
  input  logic [7:0]  alul_out,
  input  logic        alu_n,
  input  logic        alu_z,
  input  logic        alu_c,
  input  logic        alu_v
);

  state_e      state_reg, state_next;
  op_reg_t     op_reg, op_next;
  logic [3:0]  flags_reg, flags_next;
  logic [3:0]  alu_nzcv, upd_mask;
  logic        rsp_id_reg, rsp_pc_reg;
  logic [15:0] rsp_data_reg;
  logic        gnt_valid, gnt_id, accept, pagecross_next;

  rr_arb2 #(
    .ROUND_ROBIN (ROUND_ROBIN)
  ) u_arb (
    .Clk       (Clk),
    .Reset_n   (Reset_n),
    .req       ({req1_valid, req0_valid}),
    .advance   (accept),
    .gnt_valid (gnt_valid),
    .gnt_id    (gnt_id)
  );

  // The granted requester is always valid, so ready doubles as the accept.
  assign accept     = (state_reg == ST_IDLE) && gnt_valid;
  assign req0_ready = accept && !gnt_id;
  assign req1_ready = accept && gnt_id;

  assign rsp_valid     = (state_reg == ST_RESP);
  assign rsp_id        = rsp_id_reg;
  assign rsp_data      = rsp_data_reg;
  assign rsp_pagecross = rsp_pc_reg;
  assign flags         = flags_reg;

  assign pagecross_next = (op_reg.op == OP_ADD16) &&
                          (({1'b0, op_reg.a[7:0]} + {1'b0, op_reg.b[7:0]}) > 9'h0FF);

  always_comb begin
    state_next = state_reg;
    op_next    = op_reg;
    alu_op     = OP_PASS;
    aluh0      = 8'h00;
    aluh1      = 8'h00;
    alul0      = 8'h00;
    alul1      = 8'h00;
    alu_cin    = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (accept) begin
          state_next = ST_EXEC;
          if (gnt_id) begin
            op_next.op       = req1_op;
            op_next.a        = req1_a;
            op_next.b        = req1_b;
            op_next.id       = 1'b1;
            op_next.setflags = 1'b0;
          end else begin
            op_next.op       = req0_op;
            op_next.a        = req0_a;
            op_next.b        = req0_b;
            op_next.id       = 1'b0;
            op_next.setflags = req0_setflags;
          end
        end
      end
      ST_EXEC: begin
        state_next = ST_RESP;
        alu_op     = op_is_defined(op_reg.op) ? op_reg.op : OP_PASS;
        aluh0      = op_reg.a[15:8];
        alul0      = op_reg.a[7:0];
        aluh1      = op_reg.b[15:8];
        alul1      = op_reg.b[7:0];
        alu_cin    = flags_reg[FLAG_C];
      end
      ST_RESP: begin
        if (rsp_ready) begin
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // A direct flag load overrides the ALU update on all four bits.
  always_comb begin
    alu_nzcv         = 4'b0000;
    alu_nzcv[FLAG_N] = alu_n;
    alu_nzcv[FLAG_Z] = alu_z;
    alu_nzcv[FLAG_C] = alu_c;
    alu_nzcv[FLAG_V] = alu_v;
    upd_mask         = 4'b0000;
    if ((state_reg == ST_EXEC) && !op_reg.id && op_reg.setflags) begin
      upd_mask = flag_mask(op_reg.op);
    end
    flags_next = (flags_reg & ~upd_mask) | (alu_nzcv & upd_mask);
    if (flag_wr_en) begin
      flags_next = flag_wr_data;
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_reg    <= ST_IDLE;
      op_reg       <= '0;
      flags_reg    <= 4'b0000;
      rsp_id_reg   <= 1'b0;
      rsp_data_reg <= 16'h0000;
      rsp_pc_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      op_reg    <= op_next;
      flags_reg <= flags_next;
      if (state_reg == ST_EXEC) begin
        rsp_data_reg <= {aluh_out, alul_out};
        rsp_id_reg   <= op_reg.id;
        rsp_pc_reg   <= pagecross_next;
      end
    end
  end

endmodule
